// File: rtl/apple_placer.sv
// apple_placer: picks a grid cell for the next apple that is not occupied by
// the snake. Random candidates come from the free-running LFSR. After
// MAX_TRIES collisions the block switches to a raster walk from the last
// candidate, which always terminates because MAX_LEN < GRID_W*GRID_H.
//
//   state  | meaning
//   IDLE   | apple committed and drawable, waiting for eat_evt
//   PICK   | snapshot snake, choose candidate cell (random or raster)
//   SCAN   | compare candidate against snapshot segment k, one per clock
//   COMMIT | publish candidate, pulse placed, return to IDLE
module apple_placer #(
    parameter int CELL      = 10,
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int MAX_LEN   = 32,
    parameter int MAX_TRIES = 16,
    parameter int INIT_CX   = 40,
    parameter int INIT_CY   = 24
) (
    input  logic                   clk_pix,
    input  logic                   reset_n,
    input  logic                   eat_evt,
    input  logic [15:0]            rnd,
    input  logic [7:0]             snake_len,
    input  logic [MAX_LEN*10-1:0]  body_bus_x,
    input  logic [MAX_LEN*9-1:0]   body_bus_y,
    output logic [9:0]             apple_x,
    output logic [8:0]             apple_y,
    output logic                   apple_valid,
    output logic                   busy,
    output logic                   placed
);

    localparam int K_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int L_W  = $clog2(MAX_LEN + 1);
    localparam int T_W  = $clog2(MAX_TRIES + 1);
    localparam int CX_W = $clog2(GRID_W);
    localparam int CY_W = $clog2(GRID_H);

    localparam logic [9:0] INIT_PX = 10'(INIT_CX * CELL);
    localparam logic [8:0] INIT_PY = 9'(INIT_CY * CELL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PICK   = 2'd1,
        S_SCAN   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [MAX_LEN*10-1:0] r_body_x;
    logic [MAX_LEN*9-1:0]  r_body_y;
    logic [L_W-1:0]        r_len;
    logic [K_W-1:0]        r_k;
    logic [T_W-1:0]        r_tries;
    logic [CX_W-1:0]       r_cx;
    logic [CY_W-1:0]       r_cy;
    logic [9:0]            r_px;
    logic [8:0]            r_py;
    logic [9:0]            r_apple_x;
    logic [8:0]            r_apple_y;
    logic                  r_apple_valid;
    logic                  r_busy;
    logic                  r_placed;

    logic [L_W-1:0]        w_len_in;
    logic [CX_W-1:0]       w_cand_cx;
    logic [CY_W-1:0]       w_cand_cy;
    logic [9:0]            w_cand_px;
    logic [8:0]            w_cand_py;
    logic [9:0]            w_seg_x [MAX_LEN];
    logic [8:0]            w_seg_y [MAX_LEN];
    logic                  w_hit;
    logic                  w_last;

    assign apple_x     = r_apple_x;
    assign apple_y     = r_apple_y;
    assign apple_valid = r_apple_valid;
    assign busy        = r_busy;
    assign placed      = r_placed;

    // Clamp the live length to bus capacity; extra segments do not exist.
    always_comb begin
        w_len_in = snake_len[L_W-1:0];
        if (snake_len > 8'(MAX_LEN)) begin
            w_len_in = L_W'(MAX_LEN);
        end
    end

    // Candidate cell: random while tries remain, otherwise raster step from the last candidate.
    always_comb begin
        w_cand_cx = CX_W'(rnd[15:8] % 8'(GRID_W));
        w_cand_cy = CY_W'(rnd[7:0] % 8'(GRID_H));
        if (r_tries >= T_W'(MAX_TRIES)) begin
            if (r_cx == CX_W'(GRID_W - 1)) begin
                w_cand_cx = '0;
                w_cand_cy = (r_cy == CY_W'(GRID_H - 1)) ? '0 : r_cy + CY_W'(1);
            end else begin
                w_cand_cx = r_cx + CX_W'(1);
                w_cand_cy = r_cy;
            end
        end
        w_cand_px = 10'(w_cand_cx) * 10'(CELL);
        w_cand_py = 9'(w_cand_cy) * 9'(CELL);
    end

    // Unpack the snapshot buses so segment k can be selected by index.
    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            w_seg_x[k] = r_body_x[(MAX_LEN - k) * 10 - 1 -: 10];
            w_seg_y[k] = r_body_y[(MAX_LEN - k) * 9 - 1 -: 9];
        end
        w_hit  = (w_seg_x[r_k] == r_px) && (w_seg_y[r_k] == r_py);
        w_last = ({1'b0, r_k} == (r_len - L_W'(1)));
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (eat_evt) w_state_nxt = S_PICK;
            S_PICK:   w_state_nxt = (w_len_in == '0) ? S_COMMIT : S_SCAN;
            S_SCAN: begin
                if (w_hit) begin
                    w_state_nxt = S_PICK;
                end else if (w_last) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs; apple outputs move only in COMMIT.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_body_x      <= '0;
            r_body_y      <= '0;
            r_len         <= '0;
            r_k           <= '0;
            r_tries       <= '0;
            r_cx          <= CX_W'(INIT_CX);
            r_cy          <= CY_W'(INIT_CY);
            r_px          <= INIT_PX;
            r_py          <= INIT_PY;
            r_apple_x     <= INIT_PX;
            r_apple_y     <= INIT_PY;
            r_apple_valid <= 1'b1;
            r_busy        <= 1'b0;
            r_placed      <= 1'b0;
        end else begin
            r_placed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (eat_evt) begin
                        r_busy        <= 1'b1;
                        r_apple_valid <= 1'b0;
                        r_tries       <= '0;
                    end
                end
                S_PICK: begin
                    r_body_x <= body_bus_x;
                    r_body_y <= body_bus_y;
                    r_len    <= w_len_in;
                    r_cx     <= w_cand_cx;
                    r_cy     <= w_cand_cy;
                    r_px     <= w_cand_px;
                    r_py     <= w_cand_py;
                    r_k      <= '0;
                end
                S_SCAN: begin
                    if (w_hit) begin
                        if (r_tries != T_W'(MAX_TRIES)) begin
                            r_tries <= r_tries + T_W'(1);
                        end
                    end else if (!w_last) begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_apple_x     <= r_px;
                    r_apple_y     <= r_py;
                    r_placed      <= 1'b1;
                    r_apple_valid <= 1'b1;
                    r_busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer: expected apple positions are queued when
// eat_evt is driven and checked when placed fires, along with latency.
module tb_apple_placer;

    localparam int MAX_LEN = 32;

    logic                  clk_pix = 1'b0;
    logic                  reset_n;
    logic                  eat_evt;
    logic [15:0]           rnd;
    logic [7:0]            snake_len;
    logic [MAX_LEN*10-1:0] body_bus_x;
    logic [MAX_LEN*9-1:0]  body_bus_y;
    logic [9:0]            apple_x;
    logic [8:0]            apple_y;
    logic                  apple_valid;
    logic                  busy;
    logic                  placed;

    apple_placer dut (
        .clk_pix     (clk_pix),
        .reset_n     (reset_n),
        .eat_evt     (eat_evt),
        .rnd         (rnd),
        .snake_len   (snake_len),
        .body_bus_x  (body_bus_x),
        .body_bus_y  (body_bus_y),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .busy        (busy),
        .placed      (placed)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t_eat = 0;
    int   placed_cnt = 0;

    always @(posedge clk_pix) cyc++;
    always @(negedge clk_pix) if (placed === 1'b1) placed_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_seg(input int k, input int x, input int y);
        body_bus_x[(MAX_LEN - k) * 10 - 1 -: 10] = 10'(x);
        body_bus_y[(MAX_LEN - k) * 9 - 1 -: 9]   = 9'(y);
    endtask

    // Pulse eat_evt for one clock; return half a cycle after the sampling edge.
    task automatic pulse_eat(input int ex, input int ey, input string tag);
        exp_t e;
        @(negedge clk_pix);
        eat_evt = 1'b1;
        e.x = 10'(ex);
        e.y = 9'(ey);
        sb_q.push_back(e);
        @(negedge clk_pix);
        eat_evt = 1'b0;
        t_eat = cyc;
        chk({tag, "_busy_set"}, 32'(busy), 32'd1);
        chk({tag, "_valid_clr"}, 32'(apple_valid), 32'd0);
    endtask

    // Wait (bounded) for placed, checking outputs are frozen meanwhile.
    task automatic wait_placed(input int exp_lat, input string tag);
        int   n = 0;
        logic [9:0] hold_x = apple_x;
        logic [8:0] hold_y = apple_y;
        exp_t e;
        while (placed !== 1'b1 && n < 300) begin
            chk({tag, "_hold_x"}, 32'(apple_x), 32'(hold_x));
            chk({tag, "_hold_y"}, 32'(apple_y), 32'(hold_y));
            @(negedge clk_pix);
            n++;
        end
        chk({tag, "_placed"}, 32'(placed), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - t_eat), 32'(exp_lat));
        vectors++;
        assert (sb_q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_x"}, 32'(apple_x), 32'(e.x));
            chk({tag, "_y"}, 32'(apple_y), 32'(e.y));
        end
        @(negedge clk_pix);
        chk({tag, "_placed_1cyc"}, 32'(placed), 32'd0);
        chk({tag, "_valid"}, 32'(apple_valid), 32'd1);
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pc0;
        reset_n    = 1'b0;
        eat_evt    = 1'b0;
        rnd        = 16'h0A05;
        snake_len  = 8'd3;
        body_bus_x = '0;
        body_bus_y = '0;

        // Reset values, then held for 100 idle clocks.
        repeat (3) @(negedge clk_pix);
        chk("rst_x", 32'(apple_x), 32'd400);
        chk("rst_y", 32'(apple_y), 32'd240);
        chk("rst_valid", 32'(apple_valid), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_placed", 32'(placed), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_pix);
            chk("idle_x", 32'(apple_x), 32'd400);
            chk("idle_y", 32'(apple_y), 32'd240);
            chk("idle_valid", 32'(apple_valid), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_placed", 32'(placed), 32'd0);
        end

        // Free placement: cell (10,5), no conflict, L=3.
        set_seg(0, 0, 0);
        set_seg(1, 10, 0);
        set_seg(2, 20, 0);
        snake_len = 8'd3;
        rnd = 16'h0A05;
        pulse_eat(100, 50, "free");
        wait_placed(5, "free");

        // Conflict at segment 1 on first candidate, retry lands on (2,3).
        set_seg(0, 300, 300);
        set_seg(1, 100, 50);
        snake_len = 8'd2;
        rnd = 16'h0A05;
        pulse_eat(20, 30, "retry");
        @(negedge clk_pix);
        rnd = 16'h0203;
        wait_placed(4 + 3, "retry");

        // Fallback: every random draw hits the head, raster steps to (11,5).
        set_seg(0, 100, 50);
        snake_len = 8'd1;
        rnd = 16'h0A05;
        pulse_eat(110, 50, "fallback");
        wait_placed(3 + 16 * 2, "fallback");

        // Raster wrap from the last cell (63,47) back to (0,0).
        set_seg(0, 630, 470);
        snake_len = 8'd1;
        rnd = 16'h3F2F;
        pulse_eat(0, 0, "wrap");
        wait_placed(3 + 16 * 2, "wrap");

        // eat_evt while busy is ignored: exactly one placed pulse.
        set_seg(0, 0, 0);
        set_seg(1, 10, 0);
        set_seg(2, 20, 0);
        snake_len = 8'd3;
        rnd = 16'h1011;
        #1 pc0 = placed_cnt;
        pulse_eat(160, 170, "busy_ign");
        @(negedge clk_pix);
        eat_evt = 1'b1;
        @(negedge clk_pix);
        eat_evt = 1'b0;
        wait_placed(5, "busy_ign");
        repeat (20) @(negedge clk_pix);
        #1 chk("busy_ign_pulses", 32'(placed_cnt - pc0), 32'd1);

        // Async reset in the middle of a long scan: no commit afterwards.
        for (int k = 0; k < 20; k++) set_seg(k, 300 + k * 10, 400);
        snake_len = 8'd20;
        rnd = 16'h0A05;
        pulse_eat(100, 50, "midrst");
        repeat (5) @(negedge clk_pix);
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        #1 pc0 = placed_cnt;
        reset_n = 1'b0;
        #1;
        chk("midrst_x", 32'(apple_x), 32'd400);
        chk("midrst_y", 32'(apple_y), 32'd240);
        chk("midrst_valid", 32'(apple_valid), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_placed", 32'(placed), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge clk_pix);
        reset_n = 1'b1;
        repeat (40) @(negedge clk_pix);
        #1;
        chk("midrst_no_pulse", 32'(placed_cnt - pc0), 32'd0);
        chk("midrst_hold_x", 32'(apple_x), 32'd400);
        chk("midrst_hold_y", 32'(apple_y), 32'd240);
        chk("midrst_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apple_placer.md
Name: apple_placer

Overview:
- Apple position generator sitting directly upstream of the snake top level; it supplies apple_x/apple_y to the collision and pixel logic.
- On each eat event it draws a random grid cell and scans the snake body bus one segment per clock, so the apple never spawns on the snake.
- Retries with fresh random values; after a bounded number of failures it falls back to a deterministic raster-order search.

Parameters:
CELL, 10, pixel size of one grid cell
GRID_W, 64, grid width in cells
GRID_H, 48, grid height in cells
MAX_LEN, 32, segment capacity of the body buses
MAX_TRIES, 16, random candidates tried before raster fallback
INIT_CX, 40, apple cell column after reset
INIT_CY, 24, apple cell row after reset

Ports:
clk_pix  input  1  pixel clock; the block's only clock
reset_n  input  1  asynchronous, active-low reset
eat_evt  input  1  single-cycle pulse: head reached apple
rnd  input  16  free-running LFSR value
snake_len  input  8  current segment count, including the head
body_bus_x  input  MAX_LEN*10  segment x pixel coords; seg k at [(MAX_LEN-k)*10-1 -: 10], seg0 = head
body_bus_y  input  MAX_LEN*9  segment y pixel coords; seg k at [(MAX_LEN-k)*9-1 -: 9]
apple_x  output  10  apple pixel x, a multiple of CELL
apple_y  output  9  apple pixel y, a multiple of CELL
apple_valid  output  1  apple is placed and drawable
busy  output  1  placement in progress
placed  output  1  one-cycle pulse when a new position commits

Behaviour:
- Reset (async, reset_n=0):
  - apple_x=INIT_CX*CELL, apple_y=INIT_CY*CELL.
  - apple_valid=1, busy=0, placed=0.
  - State IDLE; retry counter 0.
- FSM states: IDLE, PICK, SCAN, COMMIT.
- IDLE:
  - eat_evt=1 -> PICK; busy<=1, apple_valid<=0, tries<=0.
  - eat_evt=0 -> stay.
- PICK (one cycle):
  - Snapshot snake_len and both body buses into internal registers; the scan uses only the snapshot, so snake ticks during the scan are ignored.
  - Candidate selection:
    - tries<MAX_TRIES: cx=rnd[15:8] mod GRID_W, cy=rnd[7:0] mod GRID_H.
    - Otherwise: cx=cx+1; at cx=GRID_W-1 wrap to cx=0, cy=cy+1; at cy=GRID_H-1 wrap to cy=0.
  - Store candidate pixel coords px=cx*CELL (10 bit), py=cy*CELL (9 bit).
  - Set k=0, then -> SCAN. If the snapshot length is 0 -> COMMIT directly.
- SCAN (one segment per clock):
  - hit = (seg_k.x==px) && (seg_k.y==py), exact equality.
  - hit -> tries<=tries+1 (saturates at MAX_TRIES) -> PICK.
  - No hit and k==len-1 -> COMMIT.
  - Otherwise k<=k+1.
  - Segments k>=len are never examined.
- COMMIT (one cycle):
  - apple_x<=px, apple_y<=py.
  - placed<=1 for this cycle only.
  - apple_valid<=1, busy<=0 -> IDLE.
- Latency: with length L>=1 and no conflicts, placed asserts and the outputs update L+2 clocks after the clock that samples eat_evt. Each conflict adds (index of hit segment)+2 clocks.
- eat_evt while busy=1 is ignored; no queuing.
- Termination: MAX_LEN < GRID_W*GRID_H, so the raster fallback always finds a free cell.
- Async reset mid-scan returns immediately to reset values; no partial commit.
- The outputs change only in COMMIT or on reset; they are stable in all other cycles.

Test Plan:
- Reset: reset_n low -> apple=(400,240), apple_valid=1, busy=0, placed=0; values held for 100 clocks with eat_evt=0.
- Free placement: rnd held at 16'h0A05, len=3, body at (0,0),(10,0),(20,0), pulse eat_evt -> next cycle busy=1 and apple_valid=0; 5 clocks after the eat pulse, placed=1 and apple=(100,50); apple_valid=1 and busy=0 after commit.
- Conflict retry: len=2, seg1=(100,50), rnd=16'h0A05 for the first PICK and 16'h0203 afterwards -> one retry, commit at (20,30).
- Fallback: rnd fixed at 16'h0A05, seg0=(100,50), len=1 -> 16 failed tries, then commit at (110,50).
- Raster wrap: fallback active, candidate (630,470) occupied -> commit at (0,0).
- eat_evt pulsed again while busy -> ignored, one placed pulse total; reset_n asserted mid-SCAN -> outputs return to (400,240) asynchronously, and no placed pulse follows reset release.
